// File: rtl/rv32_instr_encoder_pkg.sv
// rv32_instr_encoder_pkg: RV32I opcodes, instruction format and encoder FSM state types.
package rv32_instr_encoder_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE, ST_REJECT} state_e;
  function automatic fmt_e fmt_of(input logic [6:0] op);
    return op == OP_R ? FMT_R :
           (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? FMT_I :
           op == OP_STORE ? FMT_S :
           op == OP_BRANCH ? FMT_B :
           (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
           op == OP_JAL ? FMT_J : FMT_BAD;
  endfunction
endpackage

// File: rtl/rv32_instr_pack.sv
// rv32_instr_pack: packs RV32I fields into a machine word; ENC_RANGE_CHECK_EN enables immediate range checks.
module rv32_instr_pack
  import rv32_instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output fmt_e        fmt_o,
  output logic        range_ok_o
);
  logic        shamt;
  logic        alt_bit;
  logic [11:0] i_imm;
  always_comb begin
    fmt_o   = fmt_of(opcode_i);
    shamt   = opcode_i == OP_IMM && funct3_i[1:0] == 2'b01;
    alt_bit = (fmt_o == FMT_R || (opcode_i == OP_IMM && funct3_i == 3'b101)) ? alt_i : 1'b0;
    i_imm   = shamt ? {1'b0, alt_bit, 5'b0, imm_i[4:0]} : imm_i[11:0];
    word_o  = fmt_o == FMT_R ? {1'b0, alt_bit, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, opcode_i} :
              fmt_o == FMT_I ? {i_imm, rs1_i, funct3_i, rd_i, opcode_i} :
              fmt_o == FMT_S ? {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i} :
              fmt_o == FMT_B ? {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i} :
              fmt_o == FMT_U ? {imm_i[31:12], rd_i, opcode_i} :
              fmt_o == FMT_J ? {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i} :
              32'h0;
  end
`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = imm_i;
  always_comb
    range_ok_o = fmt_o == FMT_I ? (shamt ? imm_i[31:5] == 27'd0 : (simm >= -32'sd2048 && simm <= 32'sd2047)) :
                 fmt_o == FMT_S ? (simm >= -32'sd2048 && simm <= 32'sd2047) :
                 fmt_o == FMT_B ? (simm >= -32'sd4096 && simm <= 32'sd4094 && !imm_i[0]) :
                 fmt_o == FMT_J ? (simm >= -32'sd1048576 && simm <= 32'sd1048574 && !imm_i[0]) :
                 fmt_o == FMT_U ? imm_i[11:0] == 12'd0 :
                 1'b1;
`else
  assign range_ok_o = 1'b1;
`endif
endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: encodes RV32I field bundles and writes them sequentially to instruction memory.
// Immediate range rejection is enabled by defining ENC_RANGE_CHECK_EN.
module rv32_instr_encoder
  import rv32_instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q, done_q, err_q, last_q;
  logic [7:0]        err_cnt_q;
  logic [31:0]       word;
  fmt_e              fmt;
  logic              range_ok;
  rv32_instr_pack u_pack (
    .opcode_i  (in_opcode),
    .funct3_i  (in_funct3),
    .alt_i     (in_alt),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm_i     (in_imm),
    .word_o    (word),
    .fmt_o     (fmt),
    .range_ok_o(range_ok)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= BASE;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (in_valid) begin
            if (fmt != FMT_BAD && range_ok) begin
              wdata_q <= word;
              last_q  <= in_last;
              we_q    <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_q == 8'hff ? err_cnt_q : err_cnt_q + 8'd1;
              state_q   <= ST_REJECT;
            end
          end
        ST_WRITE:
          if (imem_ready) begin
            we_q    <= 1'b0;
            addr_q  <= addr_q + 1'b1;
            done_q  <= last_q;
            state_q <= last_q ? ST_DONE : ST_IDLE;
          end
        ST_DONE: begin
          done_q  <= 1'b0;
          addr_q  <= BASE;
          state_q <= ST_IDLE;
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  assign in_ready   = rst_n && state_q == ST_IDLE;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder: table-driven encoding checks plus stall, async-reset and saturation sequences.
module tb_rv32_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        done, err;
  logic [7:0]  err_cnt;
  int          tests = 0, fails = 0;
  int          addr_m = 0, cnt_m = 0;
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        last;
    logic        ok;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[14];
  rv32_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      tests++;
      fails++;
      $display("FAIL ready_wait: in_ready still low after 20 cycles");
    end
    in_valid = 1'b1; in_opcode = v.op; in_funct3 = v.f3; in_alt = v.alt;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm; in_last = v.last;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{7'h13, 3'd0, 1'b0, 5'd1, 5'd0,  5'd0,  32'd5,         1'b0, 1'b1, 32'h00500093};
    vecs[1]  = '{7'h33, 3'd0, 1'b0, 5'd3, 5'd1,  5'd2,  32'd0,         1'b0, 1'b1, 32'h002081B3};
    vecs[2]  = '{7'h33, 3'd0, 1'b1, 5'd3, 5'd1,  5'd2,  32'd0,         1'b0, 1'b1, 32'h402081B3};
    vecs[3]  = '{7'h03, 3'd2, 1'b0, 5'd5, 5'd2,  5'd0,  32'hFFFFFFFC,  1'b0, 1'b1, 32'hFFC12283};
    vecs[4]  = '{7'h23, 3'd2, 1'b0, 5'd9, 5'd2,  5'd5,  32'd8,         1'b0, 1'b1, 32'h00512423};
    vecs[5]  = '{7'h13, 3'd5, 1'b1, 5'd4, 5'd3,  5'd0,  32'd3,         1'b0, 1'b1, 32'h4031D213};
    vecs[6]  = '{7'h13, 3'd1, 1'b1, 5'd4, 5'd3,  5'd0,  32'd3,         1'b0, 1'b1, 32'h00319213};
    vecs[7]  = '{7'h37, 3'd7, 1'b1, 5'd7, 5'd31, 5'd31, 32'h12345000,  1'b0, 1'b1, 32'h123453B7};
    vecs[8]  = '{7'h17, 3'd0, 1'b0, 5'd1, 5'd0,  5'd0,  32'hFFFFF000,  1'b0, 1'b1, 32'hFFFFF097};
    vecs[9]  = '{7'h7F, 3'd0, 1'b0, 5'd1, 5'd1,  5'd1,  32'd5,         1'b1, 1'b0, 32'h0};
`ifdef ENC_RANGE_CHECK_EN
    vecs[10] = '{7'h13, 3'd0, 1'b0, 5'd1, 5'd0,  5'd0,  32'd2048,      1'b0, 1'b0, 32'h0};
`else
    vecs[10] = '{7'h13, 3'd0, 1'b0, 5'd1, 5'd0,  5'd0,  32'd2048,      1'b0, 1'b1, 32'h80000093};
`endif
    vecs[11] = '{7'h67, 3'd0, 1'b0, 5'd0, 5'd1,  5'd0,  32'd0,         1'b0, 1'b1, 32'h00008067};
    vecs[12] = '{7'h63, 3'd0, 1'b0, 5'd5, 5'd1,  5'd2,  32'd8,         1'b0, 1'b1, 32'h00208463};
    vecs[13] = '{7'h6F, 3'd0, 1'b0, 5'd1, 5'd0,  5'd0,  32'd2048,      1'b1, 1'b1, 32'h001000EF};
    #12;
    check("rst_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_after_rst", in_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      if (vecs[i].ok) begin
        check($sformatf("v%0d_we", i), imem_we, 1);
        check($sformatf("v%0d_data", i), imem_wdata, vecs[i].word);
        check($sformatf("v%0d_addr", i), imem_addr, addr_m);
        check($sformatf("v%0d_ready", i), in_ready, 0);
        @(negedge clk);
        addr_m = (addr_m + 1) % 1024;
        check($sformatf("v%0d_we_off", i), imem_we, 0);
        check($sformatf("v%0d_done", i), done, vecs[i].last);
        if (vecs[i].last) begin
          @(negedge clk);
          addr_m = 0;
          check($sformatf("v%0d_done_off", i), done, 0);
        end
        check($sformatf("v%0d_addr_after", i), imem_addr, addr_m);
      end else begin
        cnt_m++;
        check($sformatf("v%0d_err", i), err, 1);
        check($sformatf("v%0d_we_rej", i), imem_we, 0);
        check($sformatf("v%0d_err_cnt", i), err_cnt, cnt_m);
        check($sformatf("v%0d_addr_rej", i), imem_addr, addr_m);
        @(negedge clk);
        check($sformatf("v%0d_err_off", i), {err, done}, 0);
      end
    end
    imem_ready = 1'b0;
    apply('{7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 1'b1, 32'h0});
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("stall_we", imem_we, 1);
      check("stall_data", imem_wdata, 32'h00700113);
      check("stall_addr", imem_addr, addr_m);
      check("stall_ready", in_ready, 0);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    addr_m++;
    check("stall_done_we", imem_we, 0);
    check("stall_done_addr", imem_addr, addr_m);
    imem_ready = 1'b0;
    apply('{7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 1'b1, 32'h0});
    #2 check("pre_rst_we", imem_we, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", imem_we, 0);
    check("async_rst_addr", imem_addr, 0);
    check("async_rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    addr_m = 0;
    cnt_m = 0;
    @(negedge clk);
    apply(vecs[0]);
    @(negedge clk);
    check("post_rst_addr", imem_addr, 0);
    check("post_rst_data", imem_wdata, 32'h00500093);
    @(negedge clk);
    for (int k = 0; k < 260; k++) begin
      apply(vecs[9]);
      cnt_m = cnt_m == 255 ? 255 : cnt_m + 1;
      @(negedge clk);
    end
    check("err_cnt_sat", err_cnt, cnt_m);
    check("sat_addr", imem_addr, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Encodes RV32I instruction fields into 32-bit machine words and writes them sequentially into instruction memory. It is the inverse of the core's control decoder: it takes opcode, funct3, the alt bit (instr[30]), register indices and a full-width immediate, and packs them into R/I/S/B/U/J format. It sits between the debug/boot loader front end and the instruction-memory write port, so programs can be built on chip without a prebuilt image.

## Interface
- ADDR_W, 10: instruction-memory word-address width.
- BASE_ADDR, 0: word address of the first instruction written after reset or after a completed program.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  RV32I opcode.
- in_funct3  in  3  funct3.
- in_alt  in  1  value placed in instr[30] for R-type and for I-type shifts with funct3 101.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate as the value the decoder reconstructs; U-type takes the full upper value.
- in_last  in  1  marks the final instruction of a program.
- imem_we  out  1  write request.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- done  out  1  one-cycle pulse after the last instruction is written.
- err  out  1  one-cycle pulse when a bundle is rejected.
- err_cnt  out  8  saturating count of rejected bundles.

## Operation
- Formats by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode is rejected.
- Bit packing follows the standard RV32I layout. Fields that a format does not use are driven to 0.
- For R-type, and for opcode 0010011 with funct3 101, bit 30 = in_alt. For opcode 0010011 with funct3 001, bit 30 = 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, register the encoded word and go to WRITE, or to REJECT if the bundle is invalid.
  - WRITE: imem_we=1, in_ready=0. When imem_ready=1, imem_addr increments. The FSM then goes to DONE if the bundle had in_last set, otherwise to IDLE.
  - DONE: done=1 for one cycle, imem_addr reloads BASE_ADDR, next state IDLE.
  - REJECT: err=1 for one cycle, err_cnt increments (saturating at 255), nothing is written, imem_addr is unchanged, next state IDLE. in_last on a rejected bundle is ignored.
- imem_addr wraps from 2^ADDR_W-1 to 0 silently.
- Reset values: in_ready=0 during reset and 1 in the first cycle after it; imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, err=0, err_cnt=0, state IDLE.

## Timing
- A bundle accepted at edge N produces imem_we=1 with stable addr/data from N+1 until imem_ready is sampled high.
- Minimum cost is 2 cycles per instruction; DONE and REJECT each add one cycle.
- imem_addr, imem_wdata and imem_we do not change while imem_we=1 and imem_ready=0.
- rst_n asserted mid-WRITE drops the pending word, with imem_we low immediately (asynchronously).

## Configuration
- ENC_RANGE_CHECK_EN defined: the following bundles are rejected via REJECT:
  - I/S immediate outside -2048..2047.
  - Shift immediate outside 0..31.
  - B immediate outside -4096..4094, or odd.
  - J immediate outside ±1 MiB-2, or odd.
  - U immediate with imm[11:0]≠0.
- ENC_RANGE_CHECK_EN undefined: immediates are truncated to the field bits, and only unknown opcodes are rejected.

## Structure
- A shared package holds the opcode localparams, a format enum (R/I/S/B/U/J/BAD) and the FSM state enum.
- One combinational sub-module, rv32_instr_pack, maps fields to {word, fmt, range_ok}. The FSM, address counter and error counter live in the top level.

## Test plan
- addi x1,x0,5 (0010011, f3 0, rd 1, imm 5) -> imem_wdata 0x00500093 at BASE_ADDR; imem_addr increments.
- add x3,x1,x2 -> 0x002081B3; same fields with in_alt=1 (sub) -> 0x402081B3.
- beq x1,x2,+8 -> 0x00208463; jal x1,+2048 with in_last=1 -> 0x001000EF, then done pulses and imem_addr returns to BASE_ADDR.
- addi imm 2048: with the macro defined -> err pulse, no write, err_cnt=1; without it -> 0x80000093 is written.
- Hold imem_ready=0 for 3 cycles during WRITE -> addr/data/we held stable and in_ready=0; write completes on the 4th cycle.
- Drop rst_n mid-WRITE -> imem_we=0 asynchronously, imem_addr=BASE_ADDR, err_cnt=0; the next bundle writes at BASE_ADDR.
